// File: rtl/btn_step_pkg.sv
// Shared state type, default timing and counter sizing for the button step generator.
package btn_step_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT,
        LATCHED
    } step_state_e;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_DB_CYCLES     = 500000;
    localparam int DEF_REPEAT_DELAY  = 25000000;
    localparam int DEF_REPEAT_PERIOD = 5000000;
    localparam int DEF_CNT_W         = 8;

    // Bits needed to hold 0 .. max_count-1, never narrower than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes the raw button into the clock domain and only accepts a level
// change after it has been seen for DB_CYCLES consecutive cycles.
module btn_debounce
    import btn_step_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic stable_o
);

    localparam int DB_W = cnt_width(DB_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [DB_W-1:0]        db_cnt_q;
    logic [DB_W-1:0]        db_cnt_d;
    logic                   stable_q;
    logic                   stable_d;

    assign sync     = sync_q[SYNC_STAGES-1];
    assign stable_o = stable_q;

    // Any cycle that agrees with the accepted level restarts the stability run.
    always_comb begin
        db_cnt_d = '0;
        stable_d = stable_q;
        if (sync != stable_q) begin
            if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
                stable_d = ~stable_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            db_cnt_q <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_i};
            db_cnt_q <= db_cnt_d;
            stable_q <= stable_d;
        end
    end

endmodule

// File: rtl/btn_step_gen.sv
// Turns a debounced push-button into single-cycle step pulses with optional
// auto-repeat, and keeps a wrapping count of the steps issued.
module btn_step_gen
    import btn_step_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_i,
    input  logic             auto_en_i,
    output logic             step_o,
    output logic             held_o,
    output logic [CNT_W-1:0] step_cnt_o
);

    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = cnt_width(TMR_MAX);

    logic             stable;
    step_state_e      state_q;
    logic [TMR_W-1:0] timer_q;
    logic             step_q;
    logic [CNT_W-1:0] step_cnt_q;

    btn_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DB_CYCLES  (DB_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_i),
        .stable_o(stable)
    );

    assign step_o     = step_q;
    assign held_o     = stable;
    assign step_cnt_o = step_cnt_q;

    // Timer defaults to clear so every state entry starts from zero; a release
    // is checked first so it always wins over a repeat step due on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            step_q     <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            step_q  <= 1'b0;
            timer_q <= '0;
            case (state_q)
                IDLE: begin
                    if (stable) begin
                        step_q     <= 1'b1;
                        step_cnt_q <= step_cnt_q + CNT_W'(1);
                        state_q    <= auto_en_i ? HOLD : LATCHED;
                    end
                end
                HOLD: begin
                    if (!stable) begin
                        state_q <= IDLE;
                    end else if (!auto_en_i) begin
                        state_q <= LATCHED;
                    end else if (timer_q == TMR_W'(REPEAT_DELAY - 1)) begin
                        step_q     <= 1'b1;
                        step_cnt_q <= step_cnt_q + CNT_W'(1);
                        state_q    <= REPEAT;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                REPEAT: begin
                    if (!stable) begin
                        state_q <= IDLE;
                    end else if (!auto_en_i) begin
                        state_q <= LATCHED;
                    end else if (timer_q == TMR_W'(REPEAT_PERIOD - 1)) begin
                        step_q     <= 1'b1;
                        step_cnt_q <= step_cnt_q + CNT_W'(1);
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                LATCHED: begin
                    if (!stable) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_step_gen.sv
// Scoreboard bench: expected step edges are queued when a press is driven and
// matched against every observed step pulse.
module tb_btn_step_gen;

    localparam int LAT   = 7;
    localparam int DELAY = 8;
    localparam int PER   = 3;
    localparam int DBLAT = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       btnIn;
    logic       autoEn;
    logic       stepOut;
    logic       heldOut;
    logic [7:0] stepCnt;

    int cycle       = 0;
    int vectorCount = 0;
    int missCount   = 0;
    int expCnt      = 0;
    int expEdge;
    int expStepQ[$];

    btn_step_gen #(
        .SYNC_STAGES  (2),
        .DB_CYCLES    (4),
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(3),
        .CNT_W        (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_i     (btnIn),
        .auto_en_i (autoEn),
        .step_o    (stepOut),
        .held_o    (heldOut),
        .step_cnt_o(stepCnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectorCount++;
        if (observed != expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // Every step pulse must match the oldest queued expected edge.
    always @(negedge clk) begin
        if (stepOut) begin
            if (expStepQ.size() == 0) begin
                checkOutput("step_unexpected", cycle, -1);
            end else begin
                expEdge = expStepQ.pop_front();
                checkOutput("step_edge", cycle, expEdge);
            end
        end
    end

    task automatic waitEdges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic b, input logic a);
        btnIn  = b;
        autoEn = a;
    endtask

    task automatic pushStep(input int edgeNum);
        expStepQ.push_back(edgeNum);
        expCnt++;
    endtask

    // Auto schedule: first step, then REPEAT_DELAY, then every REPEAT_PERIOD
    // while the accepted level is still high at the deciding edge.
    task automatic pushAuto(input int base, input int releaseRel);
        int e;
        pushStep(base + LAT);
        e = LAT + DELAY;
        while (e <= releaseRel + DBLAT) begin
            pushStep(base + e);
            e += PER;
        end
    endtask

    task automatic pressAndRelease(input logic autoOn, input int holdCycles, input int settleCycles);
        int base;
        base = cycle;
        if (autoOn) pushAuto(base, holdCycles);
        else        pushStep(base + LAT);
        applyStimulus(1'b1, autoOn);
        waitEdges(holdCycles);
        applyStimulus(1'b0, autoOn);
        waitEdges(settleCycles);
    endtask

    task automatic endScenario(input string tag);
        checkOutput({tag, "_sb_empty"}, expStepQ.size(), 0);
        checkOutput({tag, "_step_cnt"}, int'(stepCnt), expCnt % 256);
    endtask

    task automatic doReset();
        rst    = 1'b1;
        expCnt = 0;
        waitEdges(3);
        rst = 1'b0;
        waitEdges(2);
    endtask

    initial begin
        int base;
        int lvl;
        int bouncePat[10] = '{1, 2, 3, 1, 2, 3, 1, 1, 3, 3};

        rst    = 1'b1;
        btnIn  = 1'b0;
        autoEn = 1'b0;
        waitEdges(2);
        checkOutput("rst_held", heldOut, 0);
        checkOutput("rst_step", stepOut, 0);
        checkOutput("rst_cnt", stepCnt, 0);
        rst = 1'b0;
        waitEdges(2);

        lvl = 1;
        foreach (bouncePat[i]) begin
            applyStimulus(lvl[0], 1'b0);
            for (int j = 0; j < bouncePat[i]; j++) begin
                waitEdges(1);
                checkOutput("bounce_held", heldOut, 0);
            end
            lvl = 1 - lvl;
        end
        applyStimulus(1'b0, 1'b0);
        waitEdges(10);
        checkOutput("bounce_settled", heldOut, 0);
        endScenario("bounce");

        base = cycle;
        pushStep(base + LAT);
        applyStimulus(1'b1, 1'b0);
        waitEdges(DBLAT - 1);
        checkOutput("press_held_early", heldOut, 0);
        waitEdges(1);
        checkOutput("press_held_rise", heldOut, 1);
        waitEdges(40 - DBLAT);
        applyStimulus(1'b0, 1'b0);
        waitEdges(DBLAT - 1);
        checkOutput("release_held_late", heldOut, 1);
        waitEdges(1);
        checkOutput("release_held_fall", heldOut, 0);
        waitEdges(10);
        endScenario("clean");

        pressAndRelease(1'b1, 30, 12);
        endScenario("auto");

        pressAndRelease(1'b1, 32, 12);
        endScenario("rel_vs_due");
        pressAndRelease(1'b1, 8, 10);
        endScenario("repress");

        doReset();
        for (int i = 0; i < 256; i++) begin
            pressAndRelease(1'b0, 8, 10);
            if (i == 254) checkOutput("wrap_pre", stepCnt, 255);
        end
        endScenario("wrap");

        base = cycle;
        pushStep(base + LAT);
        pushStep(base + LAT + DELAY);
        pushStep(base + LAT + DELAY + PER);
        applyStimulus(1'b1, 1'b1);
        waitEdges(19);
        applyStimulus(1'b1, 1'b0);
        waitEdges(5);
        applyStimulus(1'b1, 1'b1);
        waitEdges(16);
        applyStimulus(1'b0, 1'b1);
        waitEdges(10);
        endScenario("disable");
        pressAndRelease(1'b1, 8, 10);
        endScenario("disable_repress");

        base = cycle;
        pushStep(base + LAT);
        pushStep(base + LAT + DELAY);
        pushStep(base + LAT + DELAY + PER);
        applyStimulus(1'b1, 1'b1);
        waitEdges(18);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_step", stepOut, 0);
        checkOutput("arst_held", heldOut, 0);
        checkOutput("arst_cnt", stepCnt, 0);
        expCnt = 0;
        waitEdges(2);
        base = cycle;
        pushAuto(base, 22);
        rst = 1'b0;
        waitEdges(22);
        applyStimulus(1'b0, 1'b1);
        waitEdges(12);
        endScenario("arst");

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
